// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: DM access types and arbiter states.
// The DM_ARB_ALIGN_CHECK_EN build uses is_misaligned() to flag misaligned word/half accesses.
package dm_port_arbiter_pkg;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DMA = 1'b1
  } arb_state_t;

  // Byte accesses can never be misaligned; words need addr[1:0]==0, halves need addr[0]==0.
  function automatic logic is_misaligned(input logic [2:0] acc_type, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (acc_type == DM_W) begin
      bad = (addr[1:0] != 2'b00);
    end else if ((acc_type == DM_H) || (acc_type == DM_HU)) begin
      bad = addr[0];
    end
    return bad;
  endfunction

endpackage

// File: rtl/dm_port_arbiter_mux.sv
// Winner-select mux for the data-memory port: routes the granted requester's fields to dm_*
// and returns dm_rd only to the granted requester.
module dm_port_mux
  import dm_port_arbiter_pkg::*;
(
  input  logic        cpu_gnt,
  input  logic        dma_gnt,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_type,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic        dma_we,
  input  logic [2:0]  dma_type,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic [31:0] dm_rd,
  output logic        dm_we,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] cpu_rd,
  output logic [31:0] dma_rd
);

  always_comb begin
    dm_we   = 1'b0;
    dm_type = DM_W;
    dm_addr = 32'd0;
    dm_wd   = 32'd0;
    cpu_rd  = 32'd0;
    dma_rd  = 32'd0;
    if (cpu_gnt) begin
      dm_we   = cpu_we;
      dm_type = cpu_type;
      dm_addr = cpu_addr;
      dm_wd   = cpu_wd;
      cpu_rd  = dm_rd;
    end else if (dma_gnt) begin
      dm_we   = dma_we;
      dm_type = dma_type;
      dm_addr = dma_addr;
      dm_wd   = dma_wd;
      dma_rd  = dm_rd;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port data memory between the M-stage CPU access and a bursting DMA engine.
// Optional macro DM_ARB_ALIGN_CHECK_EN suppresses writes of misaligned granted accesses and raises misalign.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_type,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [2:0]  dma_type,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rd,
  output logic        dm_we,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic        misalign
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  arb_state_t    state, state_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic [BW-1:0] beat_cnt, beat_next, beat_inc;
  logic          cpu_gnt, dma_win, mux_we;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_win = 1'b0;
    if (!reset) begin
      if (state == ST_DMA) begin
        dma_win = dma_req;
      end else begin
        cpu_gnt = cpu_req && (wait_cnt < WAIT_LIMIT);
        dma_win = dma_req && !cpu_gnt;
      end
    end
  end

  assign dma_gnt   = dma_win;
  assign cpu_stall = !reset && cpu_req && !cpu_gnt;

  // A granted beat from ST_CPU is the first of its burst; a beat_cnt reaching MAX_BURST forces release.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    beat_next  = beat_cnt;
    beat_inc   = (state == ST_DMA) ? (beat_cnt + 1'b1) : BW'(1);
    if (dma_win) begin
      wait_next = '0;
    end else if (dma_req && (wait_cnt < WAIT_LIMIT)) begin
      wait_next = wait_cnt + 1'b1;
    end
    if (dma_win) begin
      if (dma_last || (beat_inc == BURST_LIMIT)) begin
        state_next = ST_CPU;
        beat_next  = '0;
      end else begin
        state_next = ST_DMA;
        beat_next  = beat_inc;
      end
    end else if ((state == ST_DMA) && !dma_req) begin
      state_next = ST_CPU;
      beat_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      beat_cnt <= beat_next;
    end
  end

  dm_port_mux u_mux (
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_win),
    .cpu_we   (cpu_we),
    .cpu_type (cpu_type),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .dma_we   (dma_we),
    .dma_type (dma_type),
    .dma_addr (dma_addr),
    .dma_wd   (dma_wd),
    .dm_rd    (dm_rd),
    .dm_we    (mux_we),
    .dm_type  (dm_type),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .cpu_rd   (cpu_rd),
    .dma_rd   (dma_rd)
  );

`ifdef DM_ARB_ALIGN_CHECK_EN
  // The handshake still completes on a misaligned access; only the memory write is suppressed.
  assign misalign = (cpu_gnt || dma_win) && is_misaligned(dm_type, dm_addr);
  assign dm_we    = mux_we && !misalign;
`else
  assign misalign = 1'b0;
  assign dm_we    = mux_we;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model and a word-addressed data memory. Honours DM_ARB_ALIGN_CHECK_EN.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_last, dma_gnt;
  logic [2:0]  dma_type;
  logic [31:0] dma_addr, dma_wd, dma_rd;
  logic        dm_we, misalign;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr, dm_wd, dm_rd;

  dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type), .dma_addr(dma_addr),
    .dma_wd(dma_wd), .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rd(dma_rd),
    .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, write on posedge, cleared by reset.
  logic [31:0] dm_mem [256];
  assign dm_rd = dm_mem[dm_addr[9:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dm_mem[i] <= 32'd0;
    end else if (dm_we) begin
      dm_mem[dm_addr[9:2]] <= dm_wd;
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: ownership, beats taken in the current burst, cycles the DMA has been starved.
  logic [31:0] ref_mem [256];
  bit m_in_burst = 0;
  int m_beats    = 0;
  int m_starve   = 0;
  bit exp_cpu, exp_dma;
  bit obs_dma_gnt, obs_stall, obs_misalign;
  logic [31:0] obs_cpu_rd;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit misalignedRule(input logic [2:0] t, input logic [31:0] a);
    if (t == DM_W) return (a % 4) != 0;
    if (t == DM_H || t == DM_HU) return (a % 2) != 0;
    return 0;
  endfunction

  task automatic setCpu(input bit req, input bit we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_type = t; cpu_addr = a; cpu_wd = d;
  endtask

  task automatic setDma(input bit req, input bit we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d, input bit last);
    dma_req = req; dma_we = we; dma_type = t; dma_addr = a; dma_wd = d; dma_last = last;
  endtask

  // One clock cycle with the currently driven inputs: check at negedge, advance model at posedge.
  task automatic applyStimulus();
    bit win, w_we, exp_mis, exp_we;
    logic [2:0]  w_type;
    logic [31:0] w_addr, w_wd, exp_cpu_rd, exp_dma_rd;
    int beats_now;
    @(negedge clk);
    exp_cpu = 0;
    exp_dma = 0;
    if (!reset) begin
      if (m_in_burst) exp_dma = dma_req;
      else begin
        exp_cpu = cpu_req && (m_starve < MAX_WAIT);
        exp_dma = dma_req && !exp_cpu;
      end
    end
    win = exp_cpu || exp_dma;
    w_we = 0; w_type = DM_W; w_addr = 0; w_wd = 0;
    if (exp_cpu) begin
      w_we = cpu_we; w_type = cpu_type; w_addr = cpu_addr; w_wd = cpu_wd;
    end else if (exp_dma) begin
      w_we = dma_we; w_type = dma_type; w_addr = dma_addr; w_wd = dma_wd;
    end
`ifdef DM_ARB_ALIGN_CHECK_EN
    exp_mis = win && misalignedRule(w_type, w_addr);
`else
    exp_mis = 0;
`endif
    exp_we = w_we && !exp_mis;
    exp_cpu_rd = exp_cpu ? ref_mem[w_addr[9:2]] : 32'd0;
    exp_dma_rd = exp_dma ? ref_mem[w_addr[9:2]] : 32'd0;
    checkOutput("dma_gnt", {31'd0, dma_gnt}, {31'd0, exp_dma});
    checkOutput("cpu_stall", {31'd0, cpu_stall}, {31'd0, !reset && cpu_req && !exp_cpu});
    checkOutput("dm_we", {31'd0, dm_we}, {31'd0, exp_we});
    checkOutput("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    checkOutput("dm_type", {29'd0, dm_type}, {29'd0, w_type});
    checkOutput("dm_addr", dm_addr, w_addr);
    checkOutput("dm_wd", dm_wd, w_wd);
    checkOutput("cpu_rd", cpu_rd, exp_cpu_rd);
    checkOutput("dma_rd", dma_rd, exp_dma_rd);
    obs_dma_gnt = dma_gnt;
    obs_stall = cpu_stall;
    obs_misalign = misalign;
    obs_cpu_rd = cpu_rd;
    @(posedge clk);
    if (reset) begin
      m_in_burst = 0; m_beats = 0; m_starve = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    end else begin
      if (exp_we) ref_mem[w_addr[9:2]] = w_wd;
      if (exp_dma) m_starve = 0;
      else if (dma_req && m_starve < MAX_WAIT) m_starve++;
      if (exp_dma) begin
        beats_now = (m_in_burst ? m_beats : 0) + 1;
        if (dma_last || beats_now >= MAX_BURST) begin
          m_in_burst = 0; m_beats = 0;
        end else begin
          m_in_burst = 1; m_beats = beats_now;
        end
      end else if (m_in_burst && !dma_req) begin
        m_in_burst = 0; m_beats = 0;
      end
    end
    #1;
  endtask

  // Runs a DMA burst of n beats at base while the CPU keeps requesting; returns grant statistics.
  task automatic runBurst(input int n, input logic [31:0] base, input int budget,
                          output int grants, output int first_run);
    int beat = 0;
    bit started = 0, ended = 0;
    grants = 0;
    first_run = 0;
    for (int cyc = 0; cyc < budget && beat < n; cyc++) begin
      setDma(1, 1, DM_W, base + 32'(4 * beat), 32'hA000_0000 + 32'(beat), beat == n - 1);
      applyStimulus();
      if (obs_dma_gnt) begin
        beat++;
        grants++;
        if (!ended) begin started = 1; first_run++; end
      end else if (started) ended = 1;
    end
    setDma(0, 0, DM_W, 0, 0, 0);
  endtask

  initial begin
    int grants, run_len, gnt_cycle, dma_beat_done;
    logic [31:0] rnd;
    reset = 1;
    setCpu(0, 0, DM_W, 0, 0);
    setDma(0, 0, DM_W, 0, 0, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    applyStimulus();
    applyStimulus();
    reset = 0;

    // CPU store then load on an idle port.
    setCpu(1, 1, DM_W, 32'h10, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("t1_sw_no_stall", {31'd0, obs_stall}, 32'd0);
    setCpu(1, 0, DM_W, 32'h10, 32'd0);
    applyStimulus();
    checkOutput("t1_lw_data", obs_cpu_rd, 32'hDEADBEEF);

    // Contention with single-beat DMA: DMA must be granted on the fifth cycle.
    setCpu(1, 0, DM_W, 32'h10, 32'd0);
    setDma(1, 1, DM_W, 32'h40, 32'h1234_5678, 1);
    gnt_cycle = 0;
    for (int cyc = 1; cyc <= 10 && gnt_cycle == 0; cyc++) begin
      applyStimulus();
      if (obs_dma_gnt) begin
        gnt_cycle = cyc;
        checkOutput("t2_stall_on_gnt", {31'd0, obs_stall}, 32'd1);
      end
    end
    checkOutput("t2_gnt_cycle", gnt_cycle, 5);
    setDma(0, 0, DM_W, 0, 0, 0);
    applyStimulus();

    // Three-beat burst: beats must be granted back to back.
    runBurst(3, 32'h100, 40, grants, run_len);
    checkOutput("t3_grants", grants, 3);
    checkOutput("t3_consecutive", run_len, 3);

    // Twelve-beat burst: forced release after MAX_BURST beats.
    runBurst(12, 32'h300, 80, grants, run_len);
    checkOutput("t4_grants", grants, 12);
    checkOutput("t4_first_run", run_len, MAX_BURST);

    // Reset in the middle of a burst once two beats have been taken.
    setCpu(0, 0, DM_W, 0, 0);
    dma_beat_done = 0;
    for (int cyc = 0; cyc < 20 && dma_beat_done < 2; cyc++) begin
      setDma(1, 1, DM_W, 32'h200 + 32'(4 * dma_beat_done), 32'hB0 + 32'(dma_beat_done), 0);
      applyStimulus();
      if (obs_dma_gnt) dma_beat_done++;
    end
    checkOutput("t5_beats_before_reset", dma_beat_done, 2);
    reset = 1;
    applyStimulus();
    checkOutput("t5_no_gnt_in_reset", {31'd0, obs_dma_gnt}, 32'd0);
    reset = 0;
    setCpu(1, 0, DM_W, 32'h200, 0);
    applyStimulus();
    checkOutput("t5_cpu_wins_after", {31'd0, obs_stall}, 32'd0);
    setDma(0, 0, DM_W, 0, 0, 0);
    applyStimulus();

    // Misaligned word store.
    setCpu(1, 1, DM_W, 32'h102, 32'hCAFEF00D);
    applyStimulus();
    setCpu(1, 0, DM_W, 32'h100, 0);
    applyStimulus();
`ifdef DM_ARB_ALIGN_CHECK_EN
    checkOutput("t6_mem_after", obs_cpu_rd, 32'd0);
`else
    checkOutput("t6_mem_after", obs_cpu_rd, 32'hCAFEF00D);
`endif

    // Random traffic; a DMA beat is held stable until the model says it was granted.
    setCpu(0, 0, DM_W, 0, 0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom % 80) == 0;
      rnd = $urandom;
      setCpu((rnd % 4) != 0, rnd[4], 3'($urandom % 5),
             {22'd0, rnd[15:8], 2'b00} | (((rnd % 5) == 0) ? 32'(rnd[17:16]) : 32'd0),
             $urandom);
      if (!(dma_req && !exp_dma)) begin
        rnd = $urandom;
        setDma((rnd % 3) != 0, rnd[5], 3'($urandom % 5),
               {22'd0, rnd[23:16], 2'b00} | (((rnd % 7) == 0) ? 32'(rnd[25:24]) : 32'd0),
               $urandom, (rnd[30:28] == 3'd0));
      end
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
